// File: rtl/gshare_global_predictor_pkg.sv
// Shared definitions for the gshare global direction predictor:
// branch opcode, 2-bit counter encodings, FSM states and the
// saturating counter update used by the pattern history table.
package gshare_global_predictor_pkg;

    // Conditional branch major opcode (RV32 BRANCH group)
    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

    // 2-bit saturating counter encodings; MSB is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    // Predictor control states: clearing the table, then normal operation
    typedef enum logic {
        FSM_INIT = 1'b0,
        FSM_RUN  = 1'b1
    } fsm_e;

    // Next counter state for a resolved outcome; sticks at both ends
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) begin
                nxt = cnt + 2'd1;
            end
        end else begin
            if (cnt != SNT) begin
                nxt = cnt - 2'd1;
            end
        end
        return nxt;
    endfunction

    // True when the instruction word belongs to the conditional branch group
    function automatic logic is_branch(input logic [31:0] inst);
        return (inst[6:0] == BRANCH_OPCODE);
    endfunction

endpackage

// File: rtl/gshare_global_predictor_sat_counter_table.sv
// Pattern history table of 2-bit saturating counters.
// One asynchronous read port, one synchronous read-modify-write
// training port and a clear port used by the initialisation sweep.
// A read that hits the entry being trained in the same cycle sees
// the updated value (write-first), so prediction never lags training.
module gshare_global_predictor_sat_counter_table
    import gshare_global_predictor_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             i_clk,
    input  logic             i_clr_en,
    input  logic [IDX_W-1:0] i_clr_idx,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_cnt
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0] r_mem [DEPTH];
    logic [1:0] w_upd_next;
    logic       w_bypass;

    // New value of the entry being trained, derived from its stored state
    always_comb begin
        w_upd_next = sat_update(r_mem[i_upd_idx], i_upd_taken);
    end

    // Read port with write-first forwarding from the training port
    always_comb begin
        w_bypass = i_upd_en && (i_upd_idx == i_rd_idx);
        o_rd_cnt = w_bypass ? w_upd_next : r_mem[i_rd_idx];
    end

    // Storage write: clearing owns the table while it runs, training otherwise
    always_ff @(posedge i_clk) begin
        if (i_clr_en) begin
            r_mem[i_clr_idx] <= WNT;
        end else if (i_upd_en) begin
            r_mem[i_upd_idx] <= w_upd_next;
        end
    end

endmodule

// File: rtl/gshare_global_predictor.sv
// Gshare global-history direction predictor.
// Holds the speculative global history register, hashes it with the
// fetch PC to index the counter table, trains with resolved outcomes
// from EX and rebuilds the history from the EX snapshot on a mispredict.
// After reset the table is swept to weak not-taken before predicting.
module gshare_global_predictor
    import gshare_global_predictor_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int GHR_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_pc_if,
    input  logic [31:0]      i_inst_if,
    input  logic             i_stall_if,
    input  logic             i_br_pre_if,
    input  logic [31:0]      i_pc_ex,
    input  logic [31:0]      i_inst_ex,
    input  logic [GHR_W-1:0] i_ghr_ex,
    input  logic             i_br_pre_ex,
    input  logic             i_br,
    output logic             o_br_pre_global,
    output logic [GHR_W-1:0] o_ghr_if,
    output logic             o_init_done
);

    fsm_e             r_state;
    fsm_e             w_state_next;
    logic [IDX_W-1:0] r_clr_cnt;
    logic [GHR_W-1:0] r_ghr;
    logic             r_init_done;

    logic             w_run;
    logic             w_clr_en;
    logic             w_if_branch;
    logic             w_ex_branch;
    logic             w_train_en;
    logic             w_ex_mispredict;
    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_train_idx;
    logic [1:0]       w_pred_cnt;
    logic             w_unused_bits;

    // Decode which stage currently carries a conditional branch
    always_comb begin
        w_if_branch     = is_branch(i_inst_if);
        w_ex_branch     = is_branch(i_inst_ex);
        w_train_en      = w_run && w_ex_branch;
        w_ex_mispredict = w_ex_branch && (i_br != i_br_pre_ex);
    end

    // Gshare hashing: word-aligned PC bits XOR zero-extended history
    always_comb begin
        w_pred_idx  = i_pc_if[IDX_W+1:2] ^ IDX_W'(r_ghr);
        w_train_idx = i_pc_ex[IDX_W+1:2] ^ IDX_W'(i_ghr_ex);
    end

    // Only bits above and below the index field are ignored by the hash
    always_comb begin
        w_unused_bits = ^{i_pc_if[31:IDX_W+2], i_pc_if[1:0],
                          i_pc_ex[31:IDX_W+2], i_pc_ex[1:0],
                          i_inst_if[31:7], i_inst_ex[31:7]};
    end

    // Control FSM state register; reset always restarts the clear sweep
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FSM_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes; reset cycle neither clears nor runs
    always_comb begin
        w_state_next = r_state;
        w_clr_en     = 1'b0;
        w_run        = 1'b0;
        case (r_state)
            FSM_INIT: begin
                w_clr_en = !i_rst;
                if (r_clr_cnt == {IDX_W{1'b1}}) begin
                    w_state_next = FSM_RUN;
                end
            end
            FSM_RUN: begin
                w_run = !i_rst;
            end
            default: begin
                w_state_next = FSM_INIT;
            end
        endcase
    end

    // Sweep pointer walks every table entry once while clearing
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clr_cnt <= '0;
        end else if (w_clr_en) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // Completion flag rises together with entry into normal operation
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_init_done <= 1'b0;
        end else if (w_clr_en && (r_clr_cnt == {IDX_W{1'b1}})) begin
            r_init_done <= 1'b1;
        end
    end

    // History update: EX repair beats the speculative IF shift, which is
    // dropped because the IF instruction is flushed on a mispredict
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ghr <= '0;
        end else if (w_run) begin
            if (w_ex_mispredict) begin
                r_ghr <= {i_ghr_ex[GHR_W-2:0], i_br};
            end else if (w_if_branch && !i_stall_if) begin
                r_ghr <= {r_ghr[GHR_W-2:0], i_br_pre_if};
            end
        end
    end

    gshare_global_predictor_sat_counter_table #(
        .IDX_W(IDX_W)
    ) u_pht (
        .i_clk       (i_clk),
        .i_clr_en    (w_clr_en),
        .i_clr_idx   (r_clr_cnt),
        .i_upd_en    (w_train_en),
        .i_upd_idx   (w_train_idx),
        .i_upd_taken (i_br),
        .i_rd_idx    (w_pred_idx),
        .o_rd_cnt    (w_pred_cnt)
    );

    // Outputs are forced to their idle values during reset and the sweep
    always_comb begin
        o_br_pre_global = w_run && w_if_branch && w_pred_cnt[1];
        o_ghr_if        = w_run ? r_ghr : '0;
        o_init_done     = r_init_done && !i_rst;
    end

endmodule

// File: tb/tb_gshare_global_predictor.sv
// Testbench for gshare_global_predictor: directed scenarios followed by
// random traffic, checked by a scoreboard against a behavioural model.
module tb_gshare_global_predictor;

    localparam int IDX_W = 6;
    localparam int GHR_W = 6;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      pcIf, instIf, pcEx, instEx;
    logic             stallIf, brPreIf, brPreEx, br;
    logic [GHR_W-1:0] ghrEx;
    logic             brPreGlobal;
    logic [GHR_W-1:0] ghrIf;
    logic             initDone;

    always #5 clk = ~clk;

    gshare_global_predictor #(.IDX_W(IDX_W), .GHR_W(GHR_W)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pc_if         (pcIf),
        .i_inst_if       (instIf),
        .i_stall_if      (stallIf),
        .i_br_pre_if     (brPreIf),
        .i_pc_ex         (pcEx),
        .i_inst_ex       (instEx),
        .i_ghr_ex        (ghrEx),
        .i_br_pre_ex     (brPreEx),
        .i_br            (br),
        .o_br_pre_global (brPreGlobal),
        .o_ghr_if        (ghrIf),
        .o_init_done     (initDone)
    );

    typedef struct {
        logic       pred;
        logic [5:0] ghr;
        logic       done;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    // Behavioural model: counters as integers, history as an integer
    int pht [DEPTH];
    int mGhr       = 0;
    int sinceReset = 0;
    bit mReady     = 0;

    function automatic bit isBr(input logic [31:0] inst);
        return inst[6:0] == 7'h63;
    endfunction

    function automatic int idxOf(input logic [31:0] pc, input int h);
        return ((int'(pc) >>> 2) ^ h) & (DEPTH - 1);
    endfunction

    function automatic int satNext(input int c, input bit taken);
        if (taken) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic logic [31:0] mkInst(input bit branch);
        logic [31:0] w;
        w = $urandom();
        w[6:0] = branch ? 7'h63 : 7'h33;
        return w;
    endfunction

    // Drive one cycle of inputs, predict the response, then advance the model
    task automatic applyStimulus(input bit r, input logic [31:0] pIf, input logic [31:0] iIf,
                                 input bit stl, input bit bpIf, input logic [31:0] pEx,
                                 input logic [31:0] iEx, input logic [5:0] gEx,
                                 input bit bpEx, input bit b);
        exp_t e;
        int   tIdx, pIdx, c;
        rst = r; pcIf = pIf; instIf = iIf; stallIf = stl; brPreIf = bpIf;
        pcEx = pEx; instEx = iEx; ghrEx = gEx; brPreEx = bpEx; br = b;
        tIdx  = idxOf(pEx, int'(gEx));
        pIdx  = idxOf(pIf, mGhr);
        e.cyc = cycle;
        if (r || !mReady) begin
            e.pred = 1'b0; e.ghr = 6'd0; e.done = 1'b0;
        end else begin
            c = pht[pIdx];
            if (isBr(iEx) && tIdx == pIdx) c = satNext(c, b);
            e.pred = isBr(iIf) && (c >= 2);
            e.ghr  = 6'(mGhr);
            e.done = 1'b1;
        end
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            sinceReset = 0; mReady = 0; mGhr = 0;
        end else if (!mReady) begin
            sinceReset++;
            if (sinceReset == DEPTH) begin
                mReady = 1;
                for (int k = 0; k < DEPTH; k++) pht[k] = 1;
            end
        end else begin
            if (isBr(iEx)) pht[tIdx] = satNext(pht[tIdx], b);
            if (isBr(iEx) && b != bpEx) mGhr = ((int'(gEx) << 1) | int'(b)) & 63;
            else if (isBr(iIf) && !stl) mGhr = ((mGhr << 1) | int'(bpIf)) & 63;
        end
        cycle++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(0, 32'h40, mkInst(0), 0, 0, 32'h80, mkInst(0), 6'd0, 0, 0);
    endtask

    task automatic checkOutput(input exp_t e);
        compared++;
        if (brPreGlobal !== e.pred) begin
            mismatched++;
            $display("[TB] FAIL br_pre_global cyc=%0d got=%0b exp=%0b", e.cyc, brPreGlobal, e.pred);
        end
        compared++;
        if (ghrIf !== e.ghr) begin
            mismatched++;
            $display("[TB] FAIL ghr_if cyc=%0d got=%b exp=%b", e.cyc, ghrIf, e.ghr);
        end
        compared++;
        if (initDone !== e.done) begin
            mismatched++;
            $display("[TB] FAIL init_done cyc=%0d got=%0b exp=%0b", e.cyc, initDone, e.done);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response
    always @(negedge clk) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    initial begin
        rst = 1; pcIf = 0; instIf = 0; stallIf = 0; brPreIf = 0;
        pcEx = 0; instEx = 0; ghrEx = 0; brPreEx = 0; br = 0;
        for (int k = 0; k < DEPTH; k++) pht[k] = 1;
        @(posedge clk);
        #1;

        // Reset, then a partial sweep with branches present in both stages
        applyStimulus(1, 32'h0, mkInst(0), 0, 0, 32'h0, mkInst(0), 6'd0, 0, 0);
        for (int k = 0; k < 30; k++)
            applyStimulus(0, 32'h100, mkInst(1), 0, 1, 32'h100, mkInst(1), 6'd0, 0, 1);

        // Reset at sweep entry 30, full sweep again
        applyStimulus(1, 32'h100, mkInst(1), 0, 1, 32'h100, mkInst(1), 6'd0, 0, 1);
        for (int k = 0; k < 64; k++)
            applyStimulus(0, 32'h100, mkInst(1), 1, 1, 32'h100, mkInst(0), 6'd0, 0, 1);
        idle(2);

        // Train pc 0x100 taken twice with a correct prediction, then predict
        applyStimulus(0, 32'h40, mkInst(0), 0, 0, 32'h100, mkInst(1), 6'd0, 1, 1);
        applyStimulus(0, 32'h40, mkInst(0), 0, 0, 32'h100, mkInst(1), 6'd0, 1, 1);
        applyStimulus(0, 32'h100, mkInst(1), 1, 0, 32'h80, mkInst(0), 6'd0, 0, 0);

        // Speculative shift, then a stalled IF branch must hold the history
        applyStimulus(0, 32'h100, mkInst(1), 0, 1, 32'h80, mkInst(0), 6'd0, 0, 0);
        applyStimulus(0, 32'h100, mkInst(1), 1, 1, 32'h80, mkInst(0), 6'd0, 0, 0);
        idle(1);

        // EX mispredict repairs history, concurrent IF shift is dropped
        applyStimulus(0, 32'h104, mkInst(1), 0, 1, 32'h200, mkInst(1), 6'b101010, 1, 0);
        idle(1);

        // Train and predict the same entry in one cycle (history now 010100)
        applyStimulus(0, 32'h200, mkInst(1), 1, 0, 32'h200, mkInst(1), 6'b010100, 1, 1);
        idle(1);

        // Saturate an entry, reset, sweep, and the entry must read weak again
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 32'h40, mkInst(0), 0, 0, 32'h300, mkInst(1), 6'd0, 1, 1);
        applyStimulus(1, 32'h40, mkInst(0), 0, 0, 32'h80, mkInst(0), 6'd0, 0, 0);
        idle(64);
        applyStimulus(0, 32'h300, mkInst(1), 1, 0, 32'h80, mkInst(0), 6'd0, 0, 0);

        // Random traffic over a small PC pool so table entries collide
        for (int k = 0; k < 800; k++) begin
            logic [31:0] pI, pE;
            logic [5:0]  g;
            pI = 32'h1000 + 32'($urandom_range(0, 15) << 2);
            pE = 32'h1000 + 32'($urandom_range(0, 15) << 2);
            g  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) g = 6'(mGhr);
            applyStimulus($urandom_range(0, 399) == 0, pI, mkInst($urandom_range(0, 9) < 7),
                          $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), pE,
                          mkInst($urandom_range(0, 9) < 6), g,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Let the monitor drain within a bounded number of cycles
        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
        #1;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
